inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//  Dual-issue instruction queue between the fetch stage and decode.
//  Accepts 0-2 fetched instructions per cycle, each carrying pc, npc and inst.
//  Presents the two oldest entries to decode, which retires 0-2 per cycle.
//  Raises stop back to fetch when it cannot take a full pair; empties on redirect.
// PARAMETERS
//  DEPTH   8   entry count; power of two, >=4
//  CW      4   count width = $clog2(DEPTH)+1
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   asynchronous, active-low reset
//  flush      in   1   mispredict redirect (ex-stage branch_flag); empties queue
//  in_en      in   1   fetch data valid this cycle (0 during fetch bubble)
//  issue      in   2   push mask from fetch: [1]=slot1, [0]=slot2
//  in1_pc     in   32  slot1 pc
//  in1_npc    in   32  slot1 predicted next pc
//  in1_inst   in   32  slot1 instruction
//  in2_pc     in   32  slot2 pc
//  in2_npc    in   32  slot2 predicted next pc
//  in2_inst   in   32  slot2 instruction
//  stop       out  1   to fetch: hold PC; asserted when free entries < 2
//  pop        in   2   decode retire count, 0..2 (3 treated as 2)
//  out_valid  out  2   [1]=head entry valid, [0]=head+1 valid
//  out1_pc    out  32  head pc       (0 when out_valid[1]=0)
//  out1_npc   out  32  head npc      (0 when out_valid[1]=0)
//  out1_inst  out  32  head inst     (0 when out_valid[1]=0)
//  out2_pc    out  32  head+1 pc     (0 when out_valid[0]=0)
//  out2_npc   out  32  head+1 npc    (0 when out_valid[0]=0)
//  out2_inst  out  32  head+1 inst   (0 when out_valid[0]=0)
//  count      out  CW  occupied entries, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=0, async):
//   - head and tail pointers = 0, count = 0.
//   - Outputs stop = 0, out_valid = 00, all outN_* = 0.
//   - Storage contents are don't-care.
//  Push (push_ok = in_en & ~stop & ~flush):
//   - issue 11: slot1 written at tail, slot2 at tail+1; tail += 2.
//   - issue 10: only slot1 written at tail; tail += 1.
//   - issue 01: only slot2 written at tail; tail += 1.
//   - issue 00: no write.
//  Pop:
//   - npop = min(pop, count at start of cycle); head += npop.
//   - Pop never exceeds current occupancy.
//   - Same-cycle pushes are not visible to pops.
//  Count and pointers:
//   - count_next = count + npush - npop.
//   - Pointers wrap modulo DEPTH.
//   - count reaches DEPTH only via exact fill; no overflow is possible
//     because stop gates pushes.
//  Combinational outputs, from registered state:
//   - stop = (count > DEPTH-2).
//   - out_valid[1] = (count >= 1); out_valid[0] = (count >= 2).
//  Latency: an entry pushed in cycle N is visible on out* in cycle N+1
//   (no bypass).
//  Flush:
//   - Highest priority. Next cycle: count = 0, head = tail = 0.
//   - Same-cycle pushes and pops are discarded.
//  Stop:
//   - Fetch data presented while stop=1 is ignored. Fetch re-presents the
//     same PC, so nothing is lost or duplicated.
//  Ordering: strict program order; slot1 is always older than slot2.
// TESTING
//  1. Reset: rst low mid-traffic -> count=0, out_valid=00, stop=0,
//     all out*=0 immediately.
//  2. Pair push: push issue=11 (pc 0x100, 0x104), pop=0 ->
//     next cycle out_valid=11, out1_pc=0x100, out2_pc=0x104, count=2.
//  3. Partial issue: issue=01 with in2_pc=0x204, then issue=10 with
//     in1_pc=0x208 -> out1_pc=0x204, out2_pc=0x208.
//  4. Fill/stop: DEPTH=8, push pairs with pop=0.
//     - After 4 pushes, count=8 and stop=1.
//     - A further issue=11 is ignored; count stays 8.
//     - pop=2 -> count=6, stop=0.
//  5. Simultaneous push/pop and wrap: count=1 with pop=2 and issue=11
//     -> npop=1, count=2.
//     - Run 20 cycles of push2/pop2 -> pc order continuous across
//       pointer wrap.
//  6. Flush: count=5 with flush=1, issue=11, pop=1 ->
//     next cycle count=0, out_valid=00, stop=0.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch/decode side signal bundle of the dual-issue instruction queue.
// The queue takes the slave modport; whoever drives fetch and decode takes master.
interface inst_queue_if #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          flush;
    logic          in_en;
    logic [1:0]    issue;
    logic [31:0]   in1_pc;
    logic [31:0]   in1_npc;
    logic [31:0]   in1_inst;
    logic [31:0]   in2_pc;
    logic [31:0]   in2_npc;
    logic [31:0]   in2_inst;
    logic          stop;
    logic [1:0]    pop;
    logic [1:0]    out_valid;
    logic [31:0]   out1_pc;
    logic [31:0]   out1_npc;
    logic [31:0]   out1_inst;
    logic [31:0]   out2_pc;
    logic [31:0]   out2_npc;
    logic [31:0]   out2_inst;
    logic [CW-1:0] count;

    modport master (
        output flush, in_en, issue,
        output in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst,
        output pop,
        input  stop, out_valid, count,
        input  out1_pc, out1_npc, out1_inst, out2_pc, out2_npc, out2_inst
    );

    modport slave (
        input  flush, in_en, issue,
        input  in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst,
        input  pop,
        output stop, out_valid, count,
        output out1_pc, out1_npc, out1_inst, out2_pc, out2_npc, out2_inst
    );
endinterface

// File: rtl/inst_queue.sv
// Dual-issue instruction queue: up to two pushes from fetch and two retires
// by decode per cycle, head pair presented from registered state (no bypass).
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    inst_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          stop;
    logic          push_ok;
    logic [1:0]    pop_req;
    logic [1:0]    npop;
    logic [1:0]    npush;
    logic          wr0_en, wr1_en;
    logic [AW-1:0] wr0_addr, wr1_addr;
    entry_t        wr0_data, wr1_data;
    entry_t        slot1, slot2;
    logic [AW-1:0] head1;

    assign stop = count_q > CW'(DEPTH - 2);

    always_comb begin
        slot1   = '{pc: q.in1_pc, npc: q.in1_npc, inst: q.in1_inst};
        slot2   = '{pc: q.in2_pc, npc: q.in2_npc, inst: q.in2_inst};
        push_ok = q.in_en & ~stop & ~q.flush;
        pop_req = (q.pop == 2'd3) ? 2'd2 : q.pop;
        // Clamp retires to occupancy at the start of the cycle; pushes this cycle are invisible.
        npop    = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;
        npush   = 2'd0;
        if (push_ok) begin
            npush = (q.issue == 2'b11) ? 2'd2 : ((q.issue != 2'b00) ? 2'd1 : 2'd0);
        end
        // A lone slot (either one) always lands at tail; slot2 goes to tail+1 only for a pair.
        wr0_en   = push_ok & (q.issue != 2'b00);
        wr0_addr = tail_q;
        wr0_data = q.issue[1] ? slot1 : slot2;
        wr1_en   = push_ok & (q.issue == 2'b11);
        wr1_addr = tail_q + AW'(1);
        wr1_data = slot2;

        head_d  = head_q + AW'(npop);
        tail_d  = tail_q + AW'(npush);
        count_d = count_q + CW'(npush) - CW'(npop);
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_q[wr0_addr] <= wr0_data;
        end
        if (wr1_en) begin
            mem_q[wr1_addr] <= wr1_data;
        end
    end

    always_comb begin
        head1       = head_q + AW'(1);
        q.stop      = stop;
        q.count     = count_q;
        q.out_valid = {count_q >= CW'(1), count_q >= CW'(2)};
        q.out1_pc   = '0;
        q.out1_npc  = '0;
        q.out1_inst = '0;
        q.out2_pc   = '0;
        q.out2_npc  = '0;
        q.out2_inst = '0;
        if (count_q >= CW'(1)) begin
            q.out1_pc   = mem_q[head_q].pc;
            q.out1_npc  = mem_q[head_q].npc;
            q.out1_inst = mem_q[head_q].inst;
        end
        if (count_q >= CW'(2)) begin
            q.out2_pc   = mem_q[head1].pc;
            q.out2_npc  = mem_q[head1].npc;
            q.out2_inst = mem_q[head1].inst;
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed vector table, hand sequences for wrap and
// mid-traffic reset, then random traffic against a queue-based model.
module tb_inst_queue;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_queue_if #(.DEPTH(DEPTH), .CW(CW)) bus ();
    inst_queue #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst(rst), .q(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        fl;
        logic        en;
        logic [1:0]  iss;
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic [1:0]  pop;
        int          cnt;
        logic [1:0]  vld;
        logic [31:0] o1;
        logic [31:0] o2;
        logic        stp;
    } vec_t;
    vec_t vt[$];

    function automatic logic [31:0] npc_of(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0013;
    endfunction

    function automatic vec_t mk(input logic fl, input logic en, input logic [1:0] iss,
                                input logic [31:0] pc1, input logic [31:0] pc2,
                                input logic [1:0] pop, input int cnt, input logic [1:0] vld,
                                input logic [31:0] o1, input logic [31:0] o2, input logic stp);
        vec_t v;
        v.fl = fl; v.en = en; v.iss = iss; v.pc1 = pc1; v.pc2 = pc2; v.pop = pop;
        v.cnt = cnt; v.vld = vld; v.o1 = o1; v.o2 = o2; v.stp = stp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic en, input logic [1:0] iss,
                         input logic [31:0] pc1, input logic [31:0] pc2, input logic [1:0] pop);
        bus.flush    = fl;
        bus.in_en    = en;
        bus.issue    = iss;
        bus.in1_pc   = pc1;
        bus.in1_npc  = npc_of(pc1);
        bus.in1_inst = inst_of(pc1);
        bus.in2_pc   = pc2;
        bus.in2_npc  = npc_of(pc2);
        bus.in2_inst = inst_of(pc2);
        bus.pop      = pop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: occupancy is the queue size; retire from the front, append at the back.
    task automatic model_update();
        int unsigned n;
        logic        stop_m;
        ent_t        e;
        if (bus.flush) begin
            mq.delete();
        end else begin
            stop_m = (mq.size() > DEPTH - 2);
            n = (bus.pop == 2'd3) ? 2 : int'(bus.pop);
            if (n > mq.size()) n = mq.size();
            repeat (n) void'(mq.pop_front());
            if (bus.in_en && !stop_m) begin
                if (bus.issue[1]) begin
                    e.pc = bus.in1_pc; e.npc = bus.in1_npc; e.inst = bus.in1_inst;
                    mq.push_back(e);
                end
                if (bus.issue[0]) begin
                    e.pc = bus.in2_pc; e.npc = bus.in2_npc; e.inst = bus.in2_inst;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic check_model();
        ent_t z;
        ent_t e1;
        ent_t e2;
        z.pc = '0; z.npc = '0; z.inst = '0;
        e1 = (mq.size() >= 1) ? mq[0] : z;
        e2 = (mq.size() >= 2) ? mq[1] : z;
        check("rnd_count", 32'(bus.count), 32'(mq.size()));
        check("rnd_valid", 32'(bus.out_valid), {30'd0, mq.size() >= 1, mq.size() >= 2});
        check("rnd_stop", 32'(bus.stop), 32'(mq.size() > DEPTH - 2));
        check("rnd_out1_pc", bus.out1_pc, e1.pc);
        check("rnd_out1_npc", bus.out1_npc, e1.npc);
        check("rnd_out1_inst", bus.out1_inst, e1.inst);
        check("rnd_out2_pc", bus.out2_pc, e2.pc);
        check("rnd_out2_npc", bus.out2_npc, e2.npc);
        check("rnd_out2_inst", bus.out2_inst, e2.inst);
    endtask

    initial begin
        //        fl  en  iss    pc1           pc2           pop    cnt vld    out1          out2          stop
        vt.push_back(mk(0, 1, 2'b11, 32'h100, 32'h104, 2'd0, 2, 2'b11, 32'h100, 32'h104, 0));
        vt.push_back(mk(0, 0, 2'b00, 32'h0,   32'h0,   2'd2, 0, 2'b00, 32'h0,   32'h0,   0));
        vt.push_back(mk(0, 1, 2'b01, 32'h0,   32'h204, 2'd0, 1, 2'b10, 32'h204, 32'h0,   0));
        vt.push_back(mk(0, 1, 2'b10, 32'h208, 32'h0,   2'd0, 2, 2'b11, 32'h204, 32'h208, 0));
        vt.push_back(mk(0, 0, 2'b00, 32'h0,   32'h0,   2'd2, 0, 2'b00, 32'h0,   32'h0,   0));
        vt.push_back(mk(0, 1, 2'b11, 32'h300, 32'h304, 2'd0, 2, 2'b11, 32'h300, 32'h304, 0));
        vt.push_back(mk(0, 1, 2'b11, 32'h308, 32'h30c, 2'd0, 4, 2'b11, 32'h300, 32'h304, 0));
        vt.push_back(mk(0, 1, 2'b11, 32'h310, 32'h314, 2'd0, 6, 2'b11, 32'h300, 32'h304, 0));
        vt.push_back(mk(0, 1, 2'b11, 32'h318, 32'h31c, 2'd0, 8, 2'b11, 32'h300, 32'h304, 1));
        vt.push_back(mk(0, 1, 2'b11, 32'h400, 32'h404, 2'd0, 8, 2'b11, 32'h300, 32'h304, 1));
        vt.push_back(mk(0, 0, 2'b00, 32'h0,   32'h0,   2'd2, 6, 2'b11, 32'h308, 32'h30c, 0));
        vt.push_back(mk(0, 0, 2'b00, 32'h0,   32'h0,   2'd3, 4, 2'b11, 32'h310, 32'h314, 0));
        vt.push_back(mk(0, 0, 2'b00, 32'h0,   32'h0,   2'd2, 2, 2'b11, 32'h318, 32'h31c, 0));
        vt.push_back(mk(0, 1, 2'b11, 32'h500, 32'h504, 2'd2, 2, 2'b11, 32'h500, 32'h504, 0));
        vt.push_back(mk(0, 0, 2'b00, 32'h0,   32'h0,   2'd1, 1, 2'b10, 32'h504, 32'h0,   0));
        vt.push_back(mk(0, 1, 2'b11, 32'h600, 32'h604, 2'd2, 2, 2'b11, 32'h600, 32'h604, 0));
        vt.push_back(mk(0, 1, 2'b11, 32'h700, 32'h704, 2'd0, 4, 2'b11, 32'h600, 32'h604, 0));
        vt.push_back(mk(0, 1, 2'b10, 32'h708, 32'h0,   2'd0, 5, 2'b11, 32'h600, 32'h604, 0));
        vt.push_back(mk(1, 1, 2'b11, 32'h800, 32'h804, 2'd1, 0, 2'b00, 32'h0,   32'h0,   0));
        vt.push_back(mk(0, 0, 2'b11, 32'h900, 32'h904, 2'd0, 0, 2'b00, 32'h0,   32'h0,   0));
        vt.push_back(mk(0, 0, 2'b00, 32'h0,   32'h0,   2'd2, 0, 2'b00, 32'h0,   32'h0,   0));

        rst = 1'b0;
        drive(0, 0, 2'b00, 32'h0, 32'h0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(bus.count), 32'd0);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_stop", 32'(bus.stop), 32'd0);
        check("reset_out1_pc", bus.out1_pc, 32'd0);
        rst = 1'b1;
        tick();

        foreach (vt[i]) begin
            drive(vt[i].fl, vt[i].en, vt[i].iss, vt[i].pc1, vt[i].pc2, vt[i].pop);
            tick();
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vt[i].cnt));
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].vld));
            check($sformatf("vec%0d_stop", i), 32'(bus.stop), 32'(vt[i].stp));
            check($sformatf("vec%0d_out1_pc", i), bus.out1_pc, vt[i].o1);
            check($sformatf("vec%0d_out2_pc", i), bus.out2_pc, vt[i].o2);
            check($sformatf("vec%0d_out1_npc", i), bus.out1_npc, (vt[i].o1 == 0) ? 32'h0 : npc_of(vt[i].o1));
            check($sformatf("vec%0d_out2_inst", i), bus.out2_inst, (vt[i].o2 == 0) ? 32'h0 : inst_of(vt[i].o2));
        end

        // Steady push2/pop2 well past several pointer wraps; program order must stay continuous.
        drive(0, 1, 2'b11, 32'hA000, 32'hA004, 2'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 2'b11, 32'hA000 + 32'(8 * (i + 1)), 32'hA004 + 32'(8 * (i + 1)), 2'd2);
            tick();
            check($sformatf("wrap%0d_out1_pc", i), bus.out1_pc, 32'hA000 + 32'(8 * (i + 1)));
            check($sformatf("wrap%0d_out2_pc", i), bus.out2_pc, 32'hA004 + 32'(8 * (i + 1)));
            check($sformatf("wrap%0d_count", i), 32'(bus.count), 32'd2);
        end

        // Asynchronous reset in the middle of traffic clears outputs without a clock edge.
        drive(0, 1, 2'b11, 32'hB000, 32'hB004, 2'd0);
        tick();
        drive(0, 1, 2'b11, 32'hB008, 32'hB00C, 2'd0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_stop", 32'(bus.stop), 32'd0);
        check("midrst_out1_pc", bus.out1_pc, 32'd0);
        check("midrst_out2_inst", bus.out2_inst, 32'd0);
        drive(0, 0, 2'b00, 32'h0, 32'h0, 2'd0);
        tick();
        rst = 1'b1;
        mq.delete();
        tick();
        check_model();

        // Random traffic: alternate fill-biased and drain-biased phases to sweep occupancy.
        for (int c = 0; c < 600; c++) begin
            logic fill;
            fill = ((c / 50) % 2) == 0;
            bus.flush    = ($urandom_range(0, 29) == 0);
            bus.in_en    = ($urandom_range(0, 3) != 0);
            bus.issue    = 2'($urandom_range(0, 3));
            bus.in1_pc   = $urandom;
            bus.in1_npc  = $urandom;
            bus.in1_inst = $urandom;
            bus.in2_pc   = $urandom;
            bus.in2_npc  = $urandom;
            bus.in2_inst = $urandom;
            bus.pop      = fill ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            tick();
            model_update();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
